// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator.
// It turns a simple valid/ready memory request into one AXI4-Lite read or
// write transaction and returns the completion on a valid/ready response port.
// The optional alignment check is enabled by defining MISALIGN_CHECK_EN.
//
// Handshake rule used on every channel: a transfer happens on a rising edge
// where valid && ready. Once valid is high it stays high, and its payload
// stays stable, until that edge. Ready may change freely.
module axi_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  // core request
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_wen,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [1:0]              i_req_size,
  input  logic [DATA_WIDTH-1:0]   i_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_req_wstrb,
  // core completion
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]              o_rsp_resp,
  // AXI4-Lite write address / data / response
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  // AXI4-Lite read address / data
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready,
  // current FSM state for observation
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WB   = 3'd2,
    S_RA   = 3'd3,
    S_RR   = 3'd4,
    S_RSP  = 3'd5
  } state_t;

  state_t state;

  // A write-side channel is finished once its valid is low or handshakes now.
  logic aw_done;
  logic w_done;
  logic misaligned;

  assign aw_done   = !awvalid || awready;
  assign w_done    = !wvalid  || wready;
  assign dbg_state = state;

`ifdef MISALIGN_CHECK_EN
  // Half needs addr[0]==0; word (size 2 or 3) needs addr[1:0]==0.
  always_comb begin
    misaligned = 1'b0;
    case (i_req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = i_req_addr[0];
      default: misaligned = (i_req_addr[1:0] != 2'b00);
    endcase
  end
`else
  // Without the check the size field has no effect on the bus.
  logic unused_size;
  assign unused_size = ^i_req_size;
  assign misaligned  = 1'b0;
`endif

  // Request/transaction/response sequencer with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_resp  <= 2'b00;
      awaddr      <= '0;
      awvalid     <= 1'b0;
      wdata       <= '0;
      wstrb       <= '0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      araddr      <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            o_req_ready <= 1'b0;
            if (misaligned) begin
              // Rejected locally: nothing goes out on the bus.
              o_rsp_valid <= 1'b1;
              o_rsp_resp  <= 2'b10;
              o_rsp_rdata <= '0;
              state       <= S_RSP;
            end else if (i_req_wen) begin
              awaddr  <= i_req_addr;
              wdata   <= i_req_wdata;
              wstrb   <= i_req_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WR;
            end else begin
              araddr  <= i_req_addr;
              arvalid <= 1'b1;
              state   <= S_RA;
            end
          end
        end
        S_WR: begin
          // AW and W retire independently; move on once both are done.
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            bready <= 1'b1;
            state  <= S_WB;
          end
        end
        S_WB: begin
          if (bvalid) begin
            bready      <= 1'b0;
            o_rsp_resp  <= bresp;
            o_rsp_rdata <= '0;
            o_rsp_valid <= 1'b1;
            state       <= S_RSP;
          end
        end
        S_RA: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RR;
          end
        end
        S_RR: begin
          if (rvalid) begin
            rready      <= 1'b0;
            o_rsp_rdata <= rdata;
            o_rsp_resp  <= rresp;
            o_rsp_valid <= 1'b1;
            state       <= S_RSP;
          end
        end
        S_RSP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_req_ready <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          o_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
